// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan controller.
package display_pkg;

    localparam int MAX_DIGITS = 16;
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_SHOW  = 2'd1,
        SCAN_BLANK = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic [3:0] idx;
        logic       wrap;
    } next_digit_t;

    // Next set bit strictly above cur; falls back to the lowest set bit and flags the wrap.
    function automatic next_digit_t next_enabled(input logic [MAX_DIGITS-1:0] mask,
                                                 input logic [3:0] cur);
        next_digit_t r;
        logic        found;
        r.idx  = cur;
        r.wrap = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (!found && (i > int'(cur)) && mask[i]) begin
                r.idx  = 4'(i);
                r.wrap = 1'b0;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (!found && mask[i]) begin
                r.idx = 4'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] lowest_enabled(input logic [MAX_DIGITS-1:0] mask);
        logic [3:0] idx;
        logic       found;
        idx   = 4'd0;
        found = 1'b0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (!found && mask[i]) begin
                idx   = 4'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/display_scan_controller_prescaler.sv
// Refresh prescaler: one-cycle tick every CLK_DIV cycles while run is high; count held at 0 otherwise.
module scan_prescaler #(
    parameter  int CLK_DIV = 100000,
    localparam int CNT_W   = $clog2(CLK_DIV)
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = run && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || !run || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Seven-segment scan controller: walks the enabled digits, drives active-low anodes and a digit index.
// Optional anti-ghosting dead time at each digit switch when SCAN_BLANK_EN is defined.
module display_scan_controller
    import display_pkg::*;
#(
    parameter  int NUM_DIGITS   = 8,
    parameter  int CLK_DIV      = 100000,
    parameter  int BLANK_CYCLES = 4,
    localparam int SEL_W        = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_DIGITS-1:0] digit_en,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [SEL_W-1:0]      seq_sel,
    output logic                  frame_start
);

    scan_state_t           r_state;
    scan_state_t           w_state_next;
    logic [SEL_W-1:0]      r_seq_sel;
    logic [SEL_W-1:0]      w_sel_next;
    logic [NUM_DIGITS-1:0] r_anode;
    logic [NUM_DIGITS-1:0] w_anode_next;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic                  r_frame_start;
    logic                  w_fs_next;
    logic                  w_go;
    logic                  w_run;
    logic                  w_tick;
    logic [MAX_DIGITS-1:0] w_mask;
    logic [3:0]            w_first;
    next_digit_t           w_next;

    assign w_mask  = MAX_DIGITS'(digit_en);
    assign w_go    = enable && (digit_en != '0);
    // Prescaler stops on the same edge the FSM drops to IDLE, so cnt lands on 0 there.
    assign w_run   = (r_state != SCAN_IDLE) && w_go;
    assign w_next  = next_enabled(w_mask, 4'(r_seq_sel));
    assign w_first = lowest_enabled(w_mask);

    scan_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (w_run),
        .tick  (w_tick)
    );

`ifdef SCAN_BLANK_EN
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    logic [BW-1:0] r_blank_cnt;
    logic          w_blank_done;

    assign w_blank_done = (r_blank_cnt == BW'(BLANK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || (r_state != SCAN_BLANK)) begin
            r_blank_cnt <= '0;
        end else begin
            r_blank_cnt <= r_blank_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_seq_sel;
        w_fs_next    = 1'b0;
        w_anode_next = ANODE_OFF[NUM_DIGITS-1:0];
        w_onehot     = '0;

        case (r_state)
            SCAN_IDLE: begin
                if (w_go) begin
                    w_state_next = SCAN_SHOW;
                    w_sel_next   = SEL_W'(w_first);
                    w_fs_next    = 1'b1;
                end
            end
            SCAN_SHOW: begin
                if (!w_go) begin
                    w_state_next = SCAN_IDLE;
                end else if (w_tick) begin
                    w_sel_next = SEL_W'(w_next.idx);
                    w_fs_next  = w_next.wrap;
`ifdef SCAN_BLANK_EN
                    w_state_next = SCAN_BLANK;
`endif
                end
            end
`ifdef SCAN_BLANK_EN
            SCAN_BLANK: begin
                if (!w_go) begin
                    w_state_next = SCAN_IDLE;
                end else if (w_blank_done) begin
                    w_state_next = SCAN_SHOW;
                end
            end
`endif
            default: begin
                w_state_next = SCAN_IDLE;
            end
        endcase

        // Masking with digit_en darkens a digit disabled mid-dwell one cycle later.
        if (w_state_next == SCAN_SHOW) begin
            w_onehot     = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_sel_next;
            w_anode_next = ~(w_onehot & digit_en);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= SCAN_IDLE;
            r_seq_sel     <= '0;
            r_anode       <= ANODE_OFF[NUM_DIGITS-1:0];
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_seq_sel     <= w_sel_next;
            r_anode       <= w_anode_next;
            r_frame_start <= w_fs_next;
        end
    end

    assign anode       = r_anode;
    assign seq_sel     = r_seq_sel;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller: directed steps plus randomized traffic vs a behavioural model.
module tb_display_scan_controller;

    localparam int N   = 8;
    localparam int DIV = 4;
    localparam int BLK = 2;
`ifdef SCAN_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [N-1:0] digit_en = '0;
    logic [N-1:0] anode;
    logic [2:0]   seq_sel;
    logic         frame_start;

    int n_cmp = 0;
    int n_fail = 0;

    // Behavioural model: which digit is shown, how long it has been shown, and whether it began with dead time.
    bit           m_active = 1'b0;
    int           m_idx = 0;
    int           m_age = 0;
    bit           m_blankph = 1'b0;
    bit           m_fs = 1'b0;
    logic [N-1:0] m_anode = '1;

    always #5 clk = ~clk;

    display_scan_controller #(
        .NUM_DIGITS   (N),
        .CLK_DIV      (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .digit_en    (digit_en),
        .anode       (anode),
        .seq_sel     (seq_sel),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic model_edge();
        int nxt;
        m_fs = 1'b0;
        if (reset) begin
            m_active = 1'b0;
            m_idx    = 0;
            m_age    = 0;
            m_anode  = '1;
        end else if (!enable || digit_en == '0) begin
            m_active = 1'b0;
            m_age    = 0;
            m_anode  = '1;
        end else begin
            if (!m_active) begin
                m_active  = 1'b1;
                m_age     = 0;
                m_blankph = 1'b0;
                m_idx     = lowest(digit_en);
                m_fs      = 1'b1;
            end else begin
                m_age++;
                if (m_age == DIV) begin
                    m_age     = 0;
                    m_blankph = BLANK_ON;
                    nxt = -1;
                    for (int i = N - 1; i > m_idx; i--) if (digit_en[i]) nxt = i;
                    if (nxt < 0) begin
                        m_idx = lowest(digit_en);
                        m_fs  = 1'b1;
                    end else begin
                        m_idx = nxt;
                    end
                end
            end
            if (m_blankph && m_age < BLK) m_anode = '1;
            else m_anode = ~((N'(1) << m_idx) & digit_en);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("anode", 16'(anode), 16'(m_anode));
        check("seq_sel", 16'(seq_sel), 16'(m_idx));
        check("frame_start", 16'(frame_start), 16'(m_fs));
        check("onehot", 16'($countones(~anode) <= 1), 16'd1);
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) step();
    endtask

    task automatic wait_sel(input logic [2:0] target, input string tag);
        for (int k = 0; k < 100; k++) begin
            if (seq_sel == target) break;
            step();
        end
        check(tag, 16'(seq_sel), 16'(target));
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        run(3);
        check("rst_anode", 16'(anode), 16'h00FF);
        check("rst_sel", 16'(seq_sel), 16'd0);
        check("rst_fs", 16'(frame_start), 16'd0);
        reset = 1'b0;
        run(2);

        // All digits enabled
        enable = 1'b1;
        digit_en = 8'hFF;
        step();
        check("start_anode", 16'(anode), 16'h00FE);
        check("start_sel", 16'(seq_sel), 16'd0);
        check("start_fs", 16'(frame_start), 16'd1);
        run(40);

        // Sparse mask and single-digit mask
        digit_en = 8'b1000_0101;
        run(40);
        digit_en = 8'h10;
        run(24);

        // Mask dropped to zero mid-dwell, then enable dropped
        digit_en = 8'hFF;
        wait_sel(3'd3, "reach_sel3_a");
        digit_en = 8'h00;
        step();
        check("mask0_anode", 16'(anode), 16'h00FF);
        check("mask0_sel", 16'(seq_sel), 16'd3);
        digit_en = 8'hFF;
        step();
        check("remask_sel", 16'(seq_sel), 16'd0);
        check("remask_fs", 16'(frame_start), 16'd1);
        wait_sel(3'd3, "reach_sel3_b");
        enable = 1'b0;
        step();
        check("dis_anode", 16'(anode), 16'h00FF);
        check("dis_sel", 16'(seq_sel), 16'd3);
        enable = 1'b1;
        step();
        check("reen_sel", 16'(seq_sel), 16'd0);
        check("reen_fs", 16'(frame_start), 16'd1);

        // Reset mid-dwell, then a glitch between edges
        wait_sel(3'd5, "reach_sel5");
        reset = 1'b1;
        step();
        check("midrst_anode", 16'(anode), 16'h00FF);
        check("midrst_sel", 16'(seq_sel), 16'd0);
        check("midrst_fs", 16'(frame_start), 16'd0);
        reset = 1'b0;
        step();
        check("post_rst_anode", 16'(anode), 16'h00FE);
        check("post_rst_fs", 16'(frame_start), 16'd1);
        run(5);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        check("glitch_anode", 16'(anode), 16'(m_anode));
        check("glitch_sel", 16'(seq_sel), 16'(m_idx));
        run(10);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            reset  = ($urandom_range(0, 99) < 2);
            enable = ($urandom_range(0, 99) < 93);
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 4))
                    0: digit_en = N'($urandom);
                    1: digit_en = N'(1) << $urandom_range(0, N - 1);
                    2: digit_en = 8'h00;
                    3: digit_en = 8'hFF;
                    default: digit_en = N'($urandom) | (N'(1) << $urandom_range(0, N - 1));
                endcase
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
